// File: rtl/qdr_client_arbiter.sv
// qdr_client_arbiter: round-robin N-client arbiter onto the QDR controller port, with read-tag return routing and drain-then-switch exclusive ownership
module qdr_client_arbiter #(
    parameter int NUM_CLIENTS     = 3,
    parameter int ADDR_BITS       = 18,
    parameter int DATA_WIDTH      = 144,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CLIENTS-1:0]            client_wr_en,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]  client_wr_addr,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wr_data,
    output logic [NUM_CLIENTS-1:0]            client_wr_ready,
    input  logic [NUM_CLIENTS-1:0]            client_rd_en,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0]  client_rd_addr,
    output logic [NUM_CLIENTS-1:0]            client_rd_ready,
    output logic [NUM_CLIENTS-1:0]            client_rd_valid,
    output logic [DATA_WIDTH-1:0]             client_rd_data,
    output logic                              ram_wr_en,
    output logic [ADDR_BITS-1:0]              ram_wr_addr,
    output logic [DATA_WIDTH-1:0]             ram_wr_data,
    output logic                              ram_rd_en,
    output logic [ADDR_BITS-1:0]              ram_rd_addr,
    input  logic                              ram_rd_valid,
    input  logic [DATA_WIDTH-1:0]             ram_rd_data,
    input  logic                              excl_req,
    input  logic [$clog2(NUM_CLIENTS)-1:0]    excl_sel,
    output logic                              excl_active,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              orphan_err
);
    localparam int CW = $clog2(NUM_CLIENTS);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {SHARED, DRAIN, EXCL} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          sel_q, last_wr, last_rd, wr_idx, rd_idx, tag_head;
    logic                   wr_hit, rd_hit, pop;
    logic [NUM_CLIENTS-1:0] allow, wr_req, rd_req;
    logic [CW-1:0]          tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]          wp, rp;

    // Nearest requester after 'last', wrapping; returns {hit, index}
    function automatic logic [CW:0] rr_pick(input logic [NUM_CLIENTS-1:0] req, input logic [CW-1:0] last);
        logic [CW:0] r;
        int idx;
        r = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CLIENTS;
            if (req[idx]) r = {1'b1, CW'(idx)};
        end
        return r;
    endfunction

    // Ownership state register; the owner is captured on the way into EXCL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SHARED;
            sel_q <= '0;
        end else begin
            state <= state_nx;
            if (state != EXCL && state_nx == EXCL) sel_q <= excl_sel;
        end
    end

    // Ownership next state: DRAIN waits until no read is in flight or returning
    always_comb begin
        state_nx = state;
        case (state)
            SHARED:  state_nx = excl_req ? DRAIN : SHARED;
            DRAIN:   state_nx = (outstanding == '0 && !ram_rd_valid) ? (excl_req ? EXCL : SHARED) : DRAIN;
            EXCL:    state_nx = (!excl_req || excl_sel != sel_q) ? DRAIN : EXCL;
            default: state_nx = SHARED;
        endcase
    end

    // Ownership outputs: which clients may be granted this cycle
    always_comb begin
        allow = (state == SHARED) ? '1 : (state == EXCL) ? NUM_CLIENTS'(1) << sel_q : '0;
    end

    // Combinational grants; reads also need room in the tag FIFO
    always_comb begin
        wr_req            = client_wr_en & allow;
        rd_req            = client_rd_en & allow & {NUM_CLIENTS{outstanding < OW'(MAX_OUTSTANDING)}};
        {wr_hit, wr_idx}  = rr_pick(wr_req, last_wr);
        {rd_hit, rd_idx}  = rr_pick(rd_req, last_rd);
        client_wr_ready   = wr_hit ? NUM_CLIENTS'(1) << wr_idx : '0;
        client_rd_ready   = rd_hit ? NUM_CLIENTS'(1) << rd_idx : '0;
        pop               = ram_rd_valid && outstanding != '0;
        tag_head          = tag_mem[rp];
    end

    // Round-robin pointers and registered request outputs to the controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr     <= CW'(NUM_CLIENTS - 1);
            last_rd     <= CW'(NUM_CLIENTS - 1);
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            ram_rd_en   <= 1'b0;
            ram_rd_addr <= '0;
        end else begin
            ram_wr_en <= wr_hit;
            ram_rd_en <= rd_hit;
            if (wr_hit) begin
                last_wr     <= wr_idx;
                ram_wr_addr <= client_wr_addr[wr_idx*ADDR_BITS +: ADDR_BITS];
                ram_wr_data <= client_wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_hit) begin
                last_rd     <= rd_idx;
                ram_rd_addr <= client_rd_addr[rd_idx*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Tag FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (rd_hit) tag_mem[wp] <= rd_idx;
    end

    // Tag FIFO pointers, in-flight count and return routing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp              <= '0;
            rp              <= '0;
            outstanding     <= '0;
            client_rd_valid <= '0;
            client_rd_data  <= '0;
            orphan_err      <= 1'b0;
            excl_active     <= 1'b0;
        end else begin
            if (rd_hit) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            outstanding     <= outstanding + OW'(rd_hit) - OW'(pop);
            client_rd_valid <= pop ? NUM_CLIENTS'(1) << tag_head : '0;
            if (pop) client_rd_data <= ram_rd_data;
            orphan_err      <= orphan_err | (ram_rd_valid && outstanding == '0);
            excl_active     <= state == EXCL;
        end
    end
endmodule

// File: tb/tb_qdr_client_arbiter.sv
// tb_qdr_client_arbiter: directed bench with a read-tag scoreboard for qdr_client_arbiter
module tb_qdr_client_arbiter;
    localparam int N = 3;
    localparam int A = 18;
    localparam int D = 144;
    localparam int M = 16;

    logic              clk, rst_n;
    logic [N-1:0]      client_wr_en, client_wr_ready, client_rd_en, client_rd_ready, client_rd_valid;
    logic [N*A-1:0]    client_wr_addr, client_rd_addr;
    logic [N*D-1:0]    client_wr_data;
    logic [D-1:0]      client_rd_data, ram_wr_data, ram_rd_data;
    logic              ram_wr_en, ram_rd_en, ram_rd_valid, excl_req, excl_active, orphan_err;
    logic [A-1:0]      ram_wr_addr, ram_rd_addr;
    logic [$clog2(N)-1:0] excl_sel;
    logic [$clog2(M):0]   outstanding;

    int   total = 0;
    int   bad = 0;
    int   rq[$];
    logic exp_orph = 1'b0;
    logic xa = 1'b0;

    qdr_client_arbiter #(.NUM_CLIENTS(N), .ADDR_BITS(A), .DATA_WIDTH(D), .MAX_OUTSTANDING(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .client_wr_en(client_wr_en), .client_wr_addr(client_wr_addr), .client_wr_data(client_wr_data),
        .client_wr_ready(client_wr_ready),
        .client_rd_en(client_rd_en), .client_rd_addr(client_rd_addr), .client_rd_ready(client_rd_ready),
        .client_rd_valid(client_rd_valid), .client_rd_data(client_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
        .excl_req(excl_req), .excl_sel(excl_sel), .excl_active(excl_active),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grants against the expected ones, update the scoreboard, clock, check registered outputs
    task automatic cyc(input logic [N-1:0] ew, input logic [N-1:0] er);
        logic [N-1:0] ev;
        logic [D-1:0] ed, ewd;
        logic [A-1:0] ewa, era;
        int wi, ri;
        #1;
        chk("wr_ready", client_wr_ready, ew);
        chk("rd_ready", client_rd_ready, er);
        ev = '0; ed = '0; wi = 0; ri = 0;
        for (int i = 0; i < N; i++) begin
            if (ew[i]) wi = i;
            if (er[i]) ri = i;
        end
        ewa = client_wr_addr[wi*A +: A];
        ewd = client_wr_data[wi*D +: D];
        era = client_rd_addr[ri*A +: A];
        if (ram_rd_valid) begin
            if (rq.size() > 0) begin
                ev = N'(1) << rq.pop_front();
                ed = ram_rd_data;
            end else exp_orph = 1'b1;
        end
        if (er != '0) rq.push_back(ri);
        @(posedge clk);
        #2;
        chk("ram_wr_en", ram_wr_en, ew != '0);
        if (ew != '0) begin
            chk("ram_wr_addr", ram_wr_addr, ewa);
            chk("ram_wr_data", ram_wr_data, ewd);
        end
        chk("ram_rd_en", ram_rd_en, er != '0);
        if (er != '0) chk("ram_rd_addr", ram_rd_addr, era);
        chk("rd_valid", client_rd_valid, ev);
        if (ev != '0) chk("rd_data", client_rd_data, ed);
        chk("outstanding", outstanding, rq.size());
        chk("orphan_err", orphan_err, exp_orph);
        chk("excl_active", excl_active, xa);
    endtask

    initial begin
        rst_n = 1'b0;
        client_wr_en = '0; client_rd_en = '0; client_wr_addr = '0; client_rd_addr = '0; client_wr_data = '0;
        ram_rd_valid = 1'b0; ram_rd_data = '0; excl_req = 1'b0; excl_sel = '0;
        for (int i = 0; i < N; i++) begin
            client_wr_addr[i*A +: A] = A'(32'h100 + i);
            client_wr_data[i*D +: D] = D'(64'hDEAD_0000_0000_0000 + i);
        end
        client_rd_addr[0*A +: A] = A'(32'h10);
        client_rd_addr[1*A +: A] = A'(32'h30);
        client_rd_addr[2*A +: A] = A'(32'h20);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_ram_wr_addr", ram_wr_addr, 0);
        chk("rst_ram_wr_data", ram_wr_data, 0);
        chk("rst_ram_rd_en", ram_rd_en, 0);
        chk("rst_ram_rd_addr", ram_rd_addr, 0);
        chk("rst_rd_valid", client_rd_valid, 0);
        chk("rst_rd_data", client_rd_data, 0);
        chk("rst_excl_active", excl_active, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", orphan_err, 0);
        rst_n = 1'b1;

        // Write round robin: 0,1,2,0,1,2
        client_wr_en = 3'b111;
        for (int k = 0; k < 6; k++) cyc(N'(1) << (k % 3), '0);
        client_wr_en = '0;
        cyc('0, '0);

        // Read fairness and return routing
        client_rd_en = 3'b101;
        cyc('0, 3'b001);
        client_rd_en = 3'b100;
        cyc('0, 3'b100);
        client_rd_en = '0;
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'hD0D0);
        cyc('0, '0);
        ram_rd_data = D'(64'hD2D2);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, '0);

        // Fill the tag FIFO, then one return reopens the read channel
        client_rd_en = 3'b010;
        for (int k = 0; k < M; k++) cyc('0, 3'b010);
        cyc('0, '0);
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'hF00D);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, 3'b010);
        client_rd_en = '0;
        ram_rd_valid = 1'b1;
        for (int k = 0; k < M; k++) begin
            ram_rd_data = D'(64'hBEEF_0000 + k);
            cyc('0, '0);
        end
        ram_rd_valid = 1'b0;
        cyc('0, '0);

        // Exclusive entry with three reads in flight
        client_rd_en = 3'b111;
        cyc('0, 3'b100);
        client_rd_en = 3'b011;
        cyc('0, 3'b001);
        client_rd_en = 3'b010;
        cyc('0, 3'b010);
        client_rd_en = '0;
        excl_req = 1'b1; excl_sel = 1;
        cyc('0, '0);
        client_wr_en = 3'b111; client_rd_en = 3'b111;
        cyc('0, '0);
        ram_rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ram_rd_data = D'(64'hE000 + k);
            cyc('0, '0);
        end
        ram_rd_valid = 1'b0;
        cyc('0, '0);
        xa = 1'b1;
        cyc(3'b010, 3'b010);
        cyc(3'b010, 3'b010);
        client_wr_en = '0; client_rd_en = '0; excl_sel = 2;
        cyc('0, '0);
        xa = 1'b0;
        client_wr_en = 3'b111; client_rd_en = 3'b111;
        cyc('0, '0);
        excl_req = 1'b0;
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'hA1);
        cyc('0, '0);
        ram_rd_data = D'(64'hA2);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, '0);
        cyc(3'b100, 3'b100);
        client_wr_en = '0; client_rd_en = '0;
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'hA3);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, '0);

        // Orphan return is flagged and sticky
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'h0BAD);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, '0);
        client_rd_en = 3'b001;
        cyc('0, 3'b001);
        client_rd_en = '0;

        // Reset mid-flight discards tags; a late return becomes an orphan
        rst_n = 1'b0;
        #1;
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_orphan", orphan_err, 0);
        chk("midrst_ram_rd_en", ram_rd_en, 0);
        rq.delete();
        exp_orph = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        ram_rd_valid = 1'b1; ram_rd_data = D'(64'h1A7E);
        cyc('0, '0);
        ram_rd_valid = 1'b0;
        cyc('0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
